// File: rtl/piece_draw_ctrl_if.sv
// rtl/piece_draw_ctrl_if.sv - request, board-read and VGA pixel signals of the piece drawer
interface piece_draw_ctrl_if;
    logic       full_req;
    logic       cell_req;
    logic [2:0] cell_x;
    logic [2:0] cell_y;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [1:0] rd_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    modport master (
        output full_req, cell_req, cell_x, cell_y, rd_data,
        input  rd_x, rd_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  full_req, cell_req, cell_x, cell_y, rd_data,
        output rd_x, rd_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/piece_draw_ctrl.sv
// rtl/piece_draw_ctrl.sv - redraws one or all 64 chessboard squares as solid pixel blocks
module piece_draw_ctrl #(
    parameter int         CELL = 4,
    parameter logic [7:0] X0   = 8'd0,
    parameter logic [6:0] Y0   = 7'd0
) (
    input  logic             clk,
    input  logic             resetn,
    piece_draw_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH_A, S_FETCH_B, S_PLOT, S_DONE} state_t;

    localparam logic [2:0] PMAX   = 3'(CELL - 1);
    localparam logic [7:0] CELL_X = 8'(CELL);
    localparam logic [6:0] CELL_Y = 7'(CELL);

    state_t     state_q, state_d;
    logic [2:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
    logic [2:0] px_q, px_d, py_q, py_d;
    logic       full_q, full_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       armed_q;
    logic       accept_full, accept_cell, last_pix, last_sq;

    function automatic logic [7:0] pix_x(input logic [2:0] sq, input logic [2:0] p);
        return X0 + ({5'd0, sq} * CELL_X) + {5'd0, p};
    endfunction

    function automatic logic [6:0] pix_y(input logic [2:0] sq, input logic [2:0] p);
        return Y0 + ({4'd0, sq} * CELL_Y) + {4'd0, p};
    endfunction

    // 2'b11 is a black piece, 2'b10 a white piece, anything else shows the green board
    function automatic logic [2:0] map_colour(input logic [1:0] s);
        case (s)
            2'b11:   return 3'b000;
            2'b10:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // armed_q blocks acceptance on the first edge after reset release
    assign accept_full = armed_q & bus.full_req;
    assign accept_cell = armed_q & bus.cell_req & ~bus.full_req;
    assign last_pix    = (px_q == PMAX) && (py_q == PMAX);
    assign last_sq     = (sq_x_q == 3'd7) && (sq_y_q == 3'd7);

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept_full || accept_cell) state_d = S_FETCH_A;
            S_FETCH_A: state_d = S_FETCH_B;
            S_FETCH_B: state_d = S_PLOT;
            S_PLOT:    if (last_pix) state_d = (full_q && !last_sq) ? S_FETCH_A : S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; read address always follows the square counters
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
        bus.rd_x = sq_x_q;
        bus.rd_y = sq_y_q;
    end

    // Datapath: pixel registers are loaded one cycle ahead so they line up with vga_plot
    always_comb begin
        sq_x_d       = sq_x_q;
        sq_y_d       = sq_y_q;
        px_d         = px_q;
        py_d         = py_q;
        full_d       = full_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_full) begin
                    sq_x_d = 3'd0;
                    sq_y_d = 3'd0;
                    full_d = 1'b1;
                end else if (accept_cell) begin
                    sq_x_d = bus.cell_x;
                    sq_y_d = bus.cell_y;
                    full_d = 1'b0;
                end
            end
            S_FETCH_B: begin
                px_d         = 3'd0;
                py_d         = 3'd0;
                vga_x_d      = pix_x(sq_x_q, 3'd0);
                vga_y_d      = pix_y(sq_y_q, 3'd0);
                vga_colour_d = map_colour(bus.rd_data);
                vga_plot_d   = 1'b1;
            end
            S_PLOT: begin
                if (last_pix) begin
                    if (full_q && !last_sq) begin
                        if (sq_x_q == 3'd7) begin
                            sq_x_d = 3'd0;
                            sq_y_d = sq_y_q + 3'd1;
                        end else begin
                            sq_x_d = sq_x_q + 3'd1;
                        end
                    end
                end else begin
                    if (px_q == PMAX) begin
                        px_d = 3'd0;
                        py_d = py_q + 3'd1;
                    end else begin
                        px_d = px_q + 3'd1;
                    end
                    vga_x_d    = pix_x(sq_x_q, px_d);
                    vga_y_d    = pix_y(sq_y_q, py_d);
                    vga_plot_d = 1'b1;
                end
            end
            S_DONE:  full_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            sq_x_q       <= 3'd0;
            sq_y_q       <= 3'd0;
            px_q         <= 3'd0;
            py_q         <= 3'd0;
            full_q       <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'b010;
            vga_plot_q   <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            sq_x_q       <= sq_x_d;
            sq_y_q       <= sq_y_d;
            px_q         <= px_d;
            py_q         <= py_d;
            full_q       <= full_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            armed_q      <= 1'b1;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_piece_draw_ctrl.sv
// tb/tb_piece_draw_ctrl.sv - randomized self-checking bench for piece_draw_ctrl
module tb_piece_draw_ctrl;
    localparam int CELL = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [1:0] board [0:7][0:7];
    pix_t got1[$], got2[$], exp_q[$];
    int   done1, done2, busy1, done_cyc1, done_cyc2, req_cyc;

    piece_draw_ctrl_if if1 ();
    piece_draw_ctrl_if if2 ();

    piece_draw_ctrl #(.CELL(CELL), .X0(8'd0), .Y0(7'd0)) dut1 (
        .clk(clk), .resetn(resetn), .bus(if1.slave));
    piece_draw_ctrl #(.CELL(CELL), .X0(8'd40), .Y0(7'd20)) dut2 (
        .clk(clk), .resetn(resetn), .bus(if2.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board memory with one-cycle synchronous read
    always @(posedge clk) begin
        if1.rd_data <= board[if1.rd_y][if1.rd_x];
        if2.rd_data <= board[if2.rd_y][if2.rd_x];
    end

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (if1.vga_plot) got1.push_back({if1.vga_x, if1.vga_y, if1.vga_colour});
        if (if2.vga_plot) got2.push_back({if2.vga_x, if2.vga_y, if2.vga_colour});
        if (if1.done) begin done1++; done_cyc1 = cyc; end
        if (if2.done) begin done2++; done_cyc2 = cyc; end
        if (if1.busy) busy1++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got1.delete(); got2.delete(); exp_q.delete();
        done1 = 0; done2 = 0; busy1 = 0; done_cyc1 = 0; done_cyc2 = 0;
    endtask

    function automatic logic [2:0] colour_of(input logic [1:0] s);
        if (s == 2'b11) return 3'b000;
        if (s == 2'b10) return 3'b111;
        return 3'b010;
    endfunction

    task automatic model_square(input int x0, input int y0, input int sx, input int sy);
        pix_t p;
        for (int py = 0; py < CELL; py++)
            for (int px = 0; px < CELL; px++) begin
                p.x = 8'((x0 + sx * CELL + px) % 256);
                p.y = 7'((y0 + sy * CELL + py) % 128);
                p.c = colour_of(board[sy][sx]);
                exp_q.push_back(p);
            end
    endtask

    task automatic model_full(input int x0, input int y0);
        for (int sy = 0; sy < 8; sy++)
            for (int sx = 0; sx < 8; sx++)
                model_square(x0, y0, sx, sy);
    endtask

    function automatic int diff_q(input int which);
        pix_t g[$];
        int   n = 0;
        g = (which == 0) ? got1 : got2;
        if (g.size() != exp_q.size()) n++;
        for (int i = 0; i < g.size() && i < exp_q.size(); i++)
            if (g[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic rand_board();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                board[y][x] = 2'($urandom_range(0, 3));
    endtask

    task automatic fill_board(input logic [1:0] v);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                board[y][x] = v;
    endtask

    task automatic wait_done(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (((which == 0) ? done1 : done2) > 0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        step();
    endtask

    task automatic test_reset();
        n_chk++; if (if1.vga_x !== 8'd0) begin n_fail++; $display("FAIL reset_vga_x: got %0d expected 0", if1.vga_x); end
        n_chk++; if (if1.vga_y !== 7'd0) begin n_fail++; $display("FAIL reset_vga_y: got %0d expected 0", if1.vga_y); end
        n_chk++; if (if1.vga_colour !== 3'b010) begin n_fail++; $display("FAIL reset_colour: got %b expected 010", if1.vga_colour); end
        n_chk++; if (if1.vga_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %b expected 0", if1.vga_plot); end
        n_chk++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if1.busy); end
        n_chk++; if (if1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", if1.done); end
        n_chk++; if ({if1.rd_x, if1.rd_y} !== 6'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d,%0d expected 0,0", if1.rd_x, if1.rd_y); end
    endtask

    task automatic test_cell_fixed();
        bit ok;
        rand_board();
        board[5][3] = 2'b11;
        clear_mon();
        model_square(0, 0, 3, 5);
        if1.cell_x = 3'd3; if1.cell_y = 3'd5; if1.cell_req = 1'b1;
        req_cyc = cyc;
        step();
        if1.cell_req = 1'b0;
        wait_done(0, 100, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cell_fixed_timeout: got %b expected 1", ok); end
        n_chk++; if (got1.size() !== 16) begin n_fail++; $display("FAIL cell_fixed_plots: got %0d expected 16", got1.size()); end
        n_chk++; if (diff_q(0) !== 0) begin n_fail++; $display("FAIL cell_fixed_pixels: got %0d bad entries expected 0", diff_q(0)); end
        if (got1.size() == 16) begin
            n_chk++; if ({got1[0].x, got1[0].y} !== {8'd12, 7'd20}) begin n_fail++; $display("FAIL cell_fixed_first: got %0d,%0d expected 12,20", got1[0].x, got1[0].y); end
            n_chk++; if ({got1[15].x, got1[15].y, got1[15].c} !== {8'd15, 7'd23, 3'b000}) begin n_fail++; $display("FAIL cell_fixed_last: got %0d,%0d,%b expected 15,23,000", got1[15].x, got1[15].y, got1[15].c); end
        end
        // request cycle through done cycle inclusive: request + 2 fetch + CELL*CELL plot + done
        n_chk++; if (done_cyc1 - req_cyc + 1 !== 1 + 2 + CELL * CELL + 1) begin n_fail++; $display("FAIL cell_fixed_latency: got %0d expected %0d", done_cyc1 - req_cyc + 1, 4 + CELL * CELL); end
        n_chk++; if (done1 !== 1) begin n_fail++; $display("FAIL cell_fixed_done_count: got %0d expected 1", done1); end
    endtask

    task automatic test_cell_random();
        bit ok;
        int cx, cy;
        for (int k = 0; k < 4; k++) begin
            rand_board();
            cx = $urandom_range(0, 7);
            cy = $urandom_range(0, 7);
            clear_mon();
            model_square(0, 0, cx, cy);
            if1.cell_x = 3'(cx); if1.cell_y = 3'(cy); if1.cell_req = 1'b1;
            step();
            if1.cell_req = 1'b0;
            wait_done(0, 100, ok);
            n_chk++; if (ok !== 1'b1 || diff_q(0) !== 0) begin n_fail++; $display("FAIL cell_random(%0d,%0d): got ok=%b bad=%0d expected ok=1 bad=0", cx, cy, ok, diff_q(0)); end
        end
    endtask

    task automatic test_offset();
        bit ok;
        rand_board();
        board[7][7] = 2'b10;
        clear_mon();
        model_square(40, 20, 7, 7);
        if2.cell_x = 3'd7; if2.cell_y = 3'd7; if2.cell_req = 1'b1;
        step();
        if2.cell_req = 1'b0;
        wait_done(1, 100, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL offset_timeout: got %b expected 1", ok); end
        n_chk++; if (diff_q(1) !== 0) begin n_fail++; $display("FAIL offset_pixels: got %0d bad entries expected 0", diff_q(1)); end
        if (got2.size() == 16) begin
            n_chk++; if ({got2[0].x, got2[0].y, got2[0].c} !== {8'd68, 7'd48, 3'b111}) begin n_fail++; $display("FAIL offset_first: got %0d,%0d,%b expected 68,48,111", got2[0].x, got2[0].y, got2[0].c); end
            n_chk++; if ({got2[15].x, got2[15].y} !== {8'd71, 7'd51}) begin n_fail++; $display("FAIL offset_last: got %0d,%0d expected 71,51", got2[15].x, got2[15].y); end
        end
    endtask

    task automatic test_full_zero();
        bit ok;
        fill_board(2'b00);
        clear_mon();
        model_full(0, 0);
        if1.full_req = 1'b1;
        step();
        if1.full_req = 1'b0;
        wait_done(0, 1300, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_zero_timeout: got %b expected 1", ok); end
        n_chk++; if (got1.size() !== 1024) begin n_fail++; $display("FAIL full_zero_plots: got %0d expected 1024", got1.size()); end
        n_chk++; if (diff_q(0) !== 0) begin n_fail++; $display("FAIL full_zero_pixels: got %0d bad entries expected 0", diff_q(0)); end
        if (got1.size() == 1024) begin
            n_chk++; if ({got1[1023].x, got1[1023].y, got1[1023].c} !== {8'd31, 7'd31, 3'b010}) begin n_fail++; $display("FAIL full_zero_last: got %0d,%0d,%b expected 31,31,010", got1[1023].x, got1[1023].y, got1[1023].c); end
        end
        n_chk++; if (done1 !== 1) begin n_fail++; $display("FAIL full_zero_done_count: got %0d expected 1", done1); end
        n_chk++; if (busy1 !== 64 * (2 + CELL * CELL) + 1) begin n_fail++; $display("FAIL full_zero_busy: got %0d expected 1153", busy1); end
    endtask

    task automatic test_full_random();
        bit ok;
        rand_board();
        clear_mon();
        model_full(0, 0);
        if1.full_req = 1'b1;
        step();
        if1.full_req = 1'b0;
        wait_done(0, 1300, ok);
        n_chk++; if (ok !== 1'b1 || diff_q(0) !== 0) begin n_fail++; $display("FAIL full_random: got ok=%b bad=%0d expected ok=1 bad=0", ok, diff_q(0)); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        rand_board();
        clear_mon();
        model_full(0, 0);
        if1.cell_x = 3'd6; if1.cell_y = 3'd6;
        if1.full_req = 1'b1; if1.cell_req = 1'b1;
        step();
        if1.full_req = 1'b0; if1.cell_req = 1'b0;
        wait_done(0, 1300, ok);
        step(); step(); step();
        n_chk++; if (ok !== 1'b1 || diff_q(0) !== 0) begin n_fail++; $display("FAIL simultaneous_pixels: got ok=%b bad=%0d expected ok=1 bad=0", ok, diff_q(0)); end
        n_chk++; if (done1 !== 1 || if1.busy !== 1'b0) begin n_fail++; $display("FAIL simultaneous_done: got done=%0d busy=%b expected 1,0", done1, if1.busy); end
    endtask

    task automatic test_busy_ignore();
        bit ok = 1'b0;
        rand_board();
        clear_mon();
        model_full(0, 0);
        if1.full_req = 1'b1;
        step();
        if1.full_req = 1'b0;
        for (int i = 0; i < 1300 && !ok; i++) begin
            if1.cell_x = 3'($urandom_range(0, 7));
            if1.cell_y = 3'($urandom_range(0, 7));
            if1.cell_req = (if1.done === 1'b1) || ($urandom_range(0, 40) == 0);
            if (if1.done === 1'b1) ok = 1'b1;
            step();
            if1.cell_req = 1'b0;
        end
        repeat (30) step();
        n_chk++; if (ok !== 1'b1 || got1.size() !== 1024 || diff_q(0) !== 0) begin n_fail++; $display("FAIL busy_ignore_plots: got ok=%b n=%0d bad=%0d expected ok=1 n=1024 bad=0", ok, got1.size(), diff_q(0)); end
        n_chk++; if (done1 !== 1 || if1.busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_done: got done=%0d busy=%b expected 1,0", done1, if1.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int n_before;
        rand_board();
        clear_mon();
        if1.full_req = 1'b1;
        step();
        if1.full_req = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (if1.vga_plot === 1'b1 && if1.vga_x === 8'd8 && if1.vga_y === 7'd0) ok = 1'b1;
        end
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_square: got %b expected 1", ok); end
        #1 resetn = 1'b1;
        #1;
        n_chk++; if (if1.vga_plot !== 1'b0 || if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_immediate: got plot=%b busy=%b expected 0,0", if1.vga_plot, if1.busy); end
        n_before = got1.size();
        repeat (3) step();
        n_chk++; if (done1 !== 0 || got1.size() !== n_before) begin n_fail++; $display("FAIL reset_mid_abandon: got done=%0d extra=%0d expected 0,0", done1, got1.size() - n_before); end
        // release mid-cycle with a request standing over the first edge after release
        resetn = 1'b0;
        if1.cell_x = 3'd1; if1.cell_y = 3'd1; if1.cell_req = 1'b1;
        @(posedge clk);
        #1 if1.cell_req = 1'b0;
        repeat (3) step();
        n_chk++; if (if1.busy !== 1'b0 || got1.size() !== n_before) begin n_fail++; $display("FAIL reset_release_edge: got busy=%b extra=%0d expected 0,0", if1.busy, got1.size() - n_before); end
        clear_mon();
        model_square(0, 0, 4, 2);
        if1.cell_x = 3'd4; if1.cell_y = 3'd2; if1.cell_req = 1'b1;
        step();
        if1.cell_req = 1'b0;
        wait_done(0, 100, ok);
        n_chk++; if (ok !== 1'b1 || diff_q(0) !== 0 || done1 !== 1) begin n_fail++; $display("FAIL reset_recover: got ok=%b bad=%0d done=%0d expected 1,0,1", ok, diff_q(0), done1); end
    endtask

    initial begin
        resetn = 1'b1;
        if1.full_req = 1'b0; if1.cell_req = 1'b0; if1.cell_x = 3'd0; if1.cell_y = 3'd0;
        if2.full_req = 1'b0; if2.cell_req = 1'b0; if2.cell_x = 3'd0; if2.cell_y = 3'd0;
        fill_board(2'b00);
        clear_mon();
        repeat (3) step();
        test_reset();
        resetn = 1'b0;
        repeat (2) step();
        test_cell_fixed();
        test_offset();
        test_cell_random();
        test_full_zero();
        test_full_random();
        test_simultaneous();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
